// File: rtl/uart_frame_parser_if.sv
// Port bundle of the UART frame parser: receiver byte
// stream in, validated command and error pulses out.
interface uart_frame_parser_if #(
  parameter int MAX_LEN = 8
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_frame_error;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [7:0]           cmd_opcode;
  logic [3:0]           cmd_len;
  logic [8*MAX_LEN-1:0] cmd_payload;
  logic                 err_chk;
  logic                 err_line;
  logic                 err_timeout;
  logic                 err_overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, rx_frame_error,
    output cmd_ready,
    input  cmd_valid, cmd_opcode, cmd_len,
    input  cmd_payload,
    input  err_chk, err_line, err_timeout,
    input  err_overrun, busy
  );

  modport slave (
    input  rx_data, rx_valid, rx_frame_error,
    input  cmd_ready,
    output cmd_valid, cmd_opcode, cmd_len,
    output cmd_payload,
    output err_chk, err_line, err_timeout,
    output err_overrun, busy
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Assembles SYNC/OPCODE/LEN/PAYLOAD/CHK packets from the
// UART byte stream and presents them on a valid/ready port.
module uart_frame_parser #(
  parameter int         MAX_LEN        = 8,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input logic               clk,
  input logic               reset_n,
  uart_frame_parser_if.slave bus
);
  localparam int PW = 8 * MAX_LEN;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_OPCODE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_HOLD
  } state_t;

  state_t        state;
  logic [1:0]    sync_q;
  logic          run;
  logic [7:0]    opcode_q;
  logic [7:0]    chk_q;
  logic [3:0]    len_q;
  logic [3:0]    idx_q;
  logic [PW-1:0] payload_q;
  logic [TW-1:0] tcnt_q;
  logic          err_chk_q;
  logic          err_line_q;
  logic          err_to_q;
  logic          err_ovr_q;
  logic          timed;
  logic          take;
  logic          line_hit;
  logic          tout;
  logic [7:0]    rx;

  // Retime reset release so the FSM starts cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], 1'b1};
  end

  assign run      = sync_q[1];
  assign rx       = bus.rx_data;
  assign take     = bus.rx_valid && !bus.rx_frame_error;
  assign line_hit = bus.rx_valid && bus.rx_frame_error;
  assign timed    = state inside {ST_OPCODE, ST_LEN,
                                  ST_PAYLOAD, ST_CHECK};
  assign tout     = timed && !bus.rx_valid &&
                    (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Packet sequencer, timeout counter and error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_HUNT;
      opcode_q   <= '0;
      chk_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      payload_q  <= '0;
      tcnt_q     <= '0;
      err_chk_q  <= 1'b0;
      err_line_q <= 1'b0;
      err_to_q   <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else if (run) begin
      err_chk_q  <= 1'b0;
      err_line_q <= 1'b0;
      err_to_q   <= 1'b0;
      err_ovr_q  <= 1'b0;
      if (bus.rx_valid)  tcnt_q <= '0;
      else if (tout)     tcnt_q <= '0;
      else if (timed)    tcnt_q <= tcnt_q + TW'(1);
      if (tout) begin
        err_to_q <= 1'b1;
        state    <= ST_HUNT;
      end
      if (line_hit && state != ST_HOLD) begin
        err_line_q <= 1'b1;
        state      <= ST_HUNT;
      end
      case (state)
        ST_HUNT: begin
          if (take && rx == SYNC_BYTE) state <= ST_OPCODE;
        end
        ST_OPCODE: begin
          if (take) begin
            opcode_q <= rx;
            chk_q    <= rx;
            state    <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (take) begin
            if (rx > 8'(MAX_LEN)) begin
              err_line_q <= 1'b1;
              state      <= ST_HUNT;
            end else begin
              len_q     <= rx[3:0];
              chk_q     <= chk_q ^ rx;
              payload_q <= '0;
              idx_q     <= '0;
              state     <= (rx == 8'd0) ? ST_CHECK
                                        : ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (take) begin
            payload_q <= payload_q |
                         (PW'(rx) << {idx_q, 3'b000});
            chk_q     <= chk_q ^ rx;
            idx_q     <= idx_q + 4'd1;
            if (idx_q + 4'd1 == len_q) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (take) begin
            if (rx == chk_q) begin
              state <= ST_HOLD;
            end else begin
              err_chk_q <= 1'b1;
              state     <= ST_HUNT;
            end
          end
        end
        ST_HOLD: begin
          if (bus.rx_valid)  err_ovr_q <= 1'b1;
          if (bus.cmd_ready) state     <= ST_HUNT;
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

  assign bus.cmd_valid   = (state == ST_HOLD);
  assign bus.busy        = (state != ST_HUNT);
  assign bus.cmd_opcode  = opcode_q;
  assign bus.cmd_len     = len_q;
  assign bus.cmd_payload = payload_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_line    = err_line_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_overrun = err_ovr_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed packets plus a
// randomized byte stream against a queue-based packet model.
module tb_uart_frame_parser;
  localparam int         ML   = 8;
  localparam int         T    = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_frame_parser_if #(.MAX_LEN(ML)) bus ();

  uart_frame_parser #(
    .MAX_LEN(ML),
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit rnd_ready   = 1'b0;

  bit          m_in   = 1'b0;
  bit          m_hold = 1'b0;
  int          m_idle = 0;
  int          m_arm  = 0;
  logic [7:0]  pkt[$];
  logic [7:0]  e_op   = '0;
  logic [3:0]  e_len  = '0;
  logic [63:0] e_pl   = '0;
  bit          e_chk  = 1'b0;
  bit          e_line = 1'b0;
  bit          e_to   = 1'b0;
  bit          e_ovr  = 1'b0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Packet-level model: bytes since SYNC kept in a queue.
  always @(posedge clk or negedge reset_n) begin : model
    int n;
    logic [7:0] x;
    if (!reset_n) begin
      m_in = 0; m_hold = 0; m_idle = 0; m_arm = 0;
      pkt.delete();
      e_op = '0; e_len = '0; e_pl = '0;
      e_chk = 0; e_line = 0; e_to = 0; e_ovr = 0;
    end else if (m_arm < 2) begin
      m_arm++;
    end else begin
      e_chk = 0; e_line = 0; e_to = 0; e_ovr = 0;
      if (m_hold) begin
        if (bus.rx_valid) e_ovr = 1;
        if (bus.cmd_ready) m_hold = 0;
      end else if (bus.rx_valid && bus.rx_frame_error) begin
        e_line = 1; m_in = 0; m_idle = 0;
      end else if (bus.rx_valid) begin
        m_idle = 0;
        if (!m_in) begin
          if (bus.rx_data == SYNC) begin
            m_in = 1;
            pkt.delete();
          end
        end else begin
          pkt.push_back(bus.rx_data);
          n = pkt.size();
          if (n == 2 && pkt[1] > ML) begin
            e_line = 1; m_in = 0;
          end else if (n >= 2 && n == int'(pkt[1]) + 3) begin
            x = 0;
            for (int i = 0; i < n - 1; i++) x ^= pkt[i];
            if (x == pkt[n-1]) begin
              m_hold = 1;
              e_op   = pkt[0];
              e_len  = pkt[1][3:0];
              e_pl   = '0;
              for (int i = 0; i < int'(pkt[1]); i++)
                e_pl |= 64'(pkt[2+i]) << (8 * i);
            end else begin
              e_chk = 1;
            end
            m_in = 0;
          end
        end
      end else if (m_in) begin
        m_idle++;
        if (m_idle == T) begin
          e_to = 1; m_in = 0; m_idle = 0;
        end
      end
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    check("cmd_valid", bus.cmd_valid, m_hold);
    check("busy", bus.busy, m_in || m_hold);
    check("err_chk", bus.err_chk, e_chk);
    check("err_line", bus.err_line, e_line);
    check("err_timeout", bus.err_timeout, e_to);
    check("err_overrun", bus.err_overrun, e_ovr);
    if (m_hold) begin
      check("cmd_opcode", bus.cmd_opcode, e_op);
      check("cmd_len", bus.cmd_len, e_len);
      check("cmd_payload", bus.cmd_payload, e_pl);
    end
  end

  task automatic tick(input bit v, input logic [7:0] d,
                      input bit fe);
    bus.rx_valid       = v;
    bus.rx_data        = d;
    bus.rx_frame_error = fe;
    if (rnd_ready) bus.cmd_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    bus.rx_valid       = 1'b0;
    bus.rx_frame_error = 1'b0;
  endtask

  task automatic drive(input logic [7:0] d, input bit fe = 0);
    tick(1'b1, d, fe);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_nominal();
    drive(8'hA5); drive(8'h10); drive(8'h03);
    drive(8'h01); drive(8'h02); drive(8'h03);
    drive(8'h13);
  endtask

  task automatic accept();
    bus.cmd_ready = 1'b1;
    idle(1);
    bus.cmd_ready = 1'b0;
  endtask

  function automatic int pick_gap();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 16) return $urandom_range(1, 2);
    if (r == 16) return T - 1;
    if (r == 17) return T;
    if (r == 18) return T + 4;
    return 3;
  endfunction

  initial begin
    logic [7:0] q[$];
    logic [7:0] x;
    int         len;
    reset_n            = 1'b1;
    bus.rx_valid       = 1'b0;
    bus.rx_data        = 8'h00;
    bus.rx_frame_error = 1'b0;
    bus.cmd_ready      = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_opcode", bus.cmd_opcode, 0);
    check("rst_payload", bus.cmd_payload, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(3);

    send_nominal();
    check("nom_valid", bus.cmd_valid, 1);
    check("nom_opcode", bus.cmd_opcode, 8'h10);
    check("nom_len", bus.cmd_len, 3);
    check("nom_payload", bus.cmd_payload, 64'h030201);
    idle(3);
    check("nom_held", bus.cmd_valid, 1);
    accept();
    check("nom_clear", bus.cmd_valid, 0);

    drive(8'h00); drive(8'hFF); drive(8'hA5);
    drive(8'h22); drive(8'h00); drive(8'h22);
    check("zl_valid", bus.cmd_valid, 1);
    check("zl_opcode", bus.cmd_opcode, 8'h22);
    check("zl_len", bus.cmd_len, 0);
    check("zl_payload", bus.cmd_payload, 0);
    accept();

    drive(8'hA5); drive(8'h10); drive(8'h01);
    drive(8'h55); drive(8'h00);
    check("chk_pulse", bus.err_chk, 1);
    check("chk_novalid", bus.cmd_valid, 0);
    idle(1);
    check("chk_single", bus.err_chk, 0);
    send_nominal();
    check("chk_next_valid", bus.cmd_valid, 1);
    accept();

    drive(8'hA5); drive(8'h10); drive(8'h03, 1'b1);
    check("fe_line", bus.err_line, 1);
    check("fe_busy", bus.busy, 0);
    idle(1);
    drive(8'hA5); drive(8'h10); drive(8'h09);
    check("len9_line", bus.err_line, 1);
    check("len9_busy", bus.busy, 0);
    idle(1);

    drive(8'hA5); drive(8'h10);
    idle(T - 1);
    check("to_busy_pre", bus.busy, 1);
    check("to_none_pre", bus.err_timeout, 0);
    idle(1);
    check("to_pulse", bus.err_timeout, 1);
    check("to_busy", bus.busy, 0);
    idle(1);
    check("to_single", bus.err_timeout, 0);
    drive(8'hA5); drive(8'h10);
    idle(T - 1);
    drive(8'h03);
    check("alive_busy", bus.busy, 1);
    check("alive_no_to", bus.err_timeout, 0);
    drive(8'h01); drive(8'h02); drive(8'h03); drive(8'h13);
    check("alive_valid", bus.cmd_valid, 1);

    drive(8'h55);
    check("ovr1", bus.err_overrun, 1);
    check("ovr1_opcode", bus.cmd_opcode, 8'h10);
    drive(8'h66);
    check("ovr2", bus.err_overrun, 1);
    check("ovr2_payload", bus.cmd_payload, 64'h030201);
    idle(1);
    check("ovr_single", bus.err_overrun, 0);
    check("ovr_valid", bus.cmd_valid, 1);
    accept();

    drive(8'hA5); drive(8'h10); drive(8'h02);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_opcode", bus.cmd_opcode, 0);
    check("mid_rst_len", bus.cmd_len, 0);
    check("mid_rst_payload", bus.cmd_payload, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(3);

    rnd_ready = 1'b1;
    for (int p = 0; p < 250; p++) begin
      q.delete();
      if ($urandom_range(0, 9) == 0)
        q.push_back(8'($urandom_range(0, 255)));
      len = ($urandom_range(0, 9) == 0) ?
            $urandom_range(9, 15) : $urandom_range(0, ML);
      q.push_back(SYNC);
      q.push_back(8'($urandom_range(0, 255)));
      q.push_back(8'(len));
      x = q[q.size()-1] ^ q[q.size()-2];
      for (int i = 0; i < len; i++) begin
        q.push_back(8'($urandom_range(0, 255)));
        x ^= q[q.size()-1];
      end
      if ($urandom_range(0, 6) == 0)
        x ^= 8'(1 << $urandom_range(0, 7));
      q.push_back(x);
      foreach (q[i]) begin
        drive(q[i], $urandom_range(0, 39) == 0);
        idle(pick_gap());
      end
    end
    rnd_ready     = 1'b0;
    bus.cmd_ready = 1'b1;
    idle(T + 4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Sequencer behind the UART receiver: consumes the byte stream produced by the receive path (`rx_data`/`valid`/`frame_error`) and assembles framed command packets of the form SYNC, OPCODE, LEN, PAYLOAD[LEN], CHK. Validated packets are presented on a valid/ready command port to the game-control logic. Framing, checksum, line and inter-byte-timeout errors are reported as single-cycle pulses, and the parser resynchronises to the next SYNC.

## Interface
- `MAX_LEN`, default 8: maximum payload bytes (1..15).
- `SYNC_BYTE`, default 8'hA5: start-of-packet marker.
- `TIMEOUT_CYCLES`, default 100000: maximum clk cycles allowed between consecutive bytes of one packet (≥2).
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte; qualified by `rx_valid`.
- `rx_valid` in 1: single-cycle strobe from the receiver.
- `rx_frame_error` in 1: concurrent with `rx_valid`; byte had a bad stop bit.
- `cmd_valid` out 1: packet available.
- `cmd_ready` in 1: consumer accepts the packet when high together with `cmd_valid`.
- `cmd_opcode` out 8: packet opcode.
- `cmd_len` out 4: payload length.
- `cmd_payload` out 8*MAX_LEN: byte i occupies bits [8i+7:8i]; bytes ≥ `cmd_len` read as zero.
- `err_chk` out 1: pulse on checksum mismatch.
- `err_line` out 1: pulse on receiver frame error or LEN > MAX_LEN.
- `err_timeout` out 1: pulse on inter-byte timeout.
- `err_overrun` out 1: pulse on a byte dropped while holding.
- `busy` out 1: high in any state other than HUNT.

## Operation
- States: HUNT, OPCODE, LEN, PAYLOAD, CHECK, HOLD.
- HUNT: a byte equal to SYNC_BYTE moves to OPCODE. Any other byte is discarded without an error.
- OPCODE: latch the opcode, set chk = opcode, go to LEN.
- LEN: if LEN > MAX_LEN, pulse `err_line` and go to HUNT. Otherwise latch LEN, chk ^= LEN, clear the payload register, index = 0. Go to PAYLOAD if LEN ≠ 0, else go to CHECK.
- PAYLOAD: store the byte at `index`, chk ^= byte, index++. After the LEN-th byte, go to CHECK.
- CHECK: if byte == chk, go to HOLD with `cmd_valid` = 1. Otherwise pulse `err_chk` and go to HUNT.
- HOLD: `cmd_*` outputs are stable. On `cmd_valid && cmd_ready`, go to HUNT and clear `cmd_valid`. A byte arriving in HOLD is dropped, pulses `err_overrun`, and does not change state.
- `rx_frame_error` with `rx_valid` in any state except HOLD: pulse `err_line` and go to HUNT; the byte is discarded (even if it equals SYNC). In HOLD it counts as an overrun.
- Timeout counter: reset to 0 on every accepted byte. It increments every cycle in OPCODE, LEN, PAYLOAD and CHECK. Reaching TIMEOUT_CYCLES−1 pulses `err_timeout` and returns to HUNT. The counter is frozen in HUNT and HOLD.
- The checksum is an 8-bit XOR and wraps naturally; no carry.

## Timing
- Reset (asynchronous assert): state = HUNT. `cmd_valid`, all `err_*` and `busy` = 0. `cmd_opcode`, `cmd_len`, `cmd_payload`, index, chk and the timeout counter = 0.
- Reset deassertion is synchronised internally by two flops before the state machine leaves reset.
- A byte is processed in the cycle `rx_valid` is high; the state updates on that edge.
- Latency: `cmd_valid` rises on the edge after the CHK byte's `rx_valid` (1 cycle).
- `err_*` outputs are registered, high for exactly one cycle, on the edge after the causing event.
- Handshake: `cmd_valid` stays high until it is sampled with `cmd_ready` = 1. Outputs must not change while `cmd_valid` is high. `cmd_ready` may be high before `cmd_valid`.
- Simultaneous handshake and `rx_valid` in HOLD: the byte counts as an overrun (it is dropped) and the state returns to HUNT.
- A timeout and `rx_valid` in the same cycle: the byte wins and the counter clears.
- Reset asserted mid-packet: the partial packet is discarded and no error pulse is issued.

## Test plan
- Nominal packet: A5,10,03,01,02,03,CHK=13 -> one `cmd_valid` with opcode 8'h10, len 3, payload 24'h030201. Held until `cmd_ready`, then cleared one cycle later.
- Zero length plus garbage: 00,FF,A5,22,00,22 -> leading bytes ignored with no errors; packet with opcode 8'h22, len 0, payload 0.
- Checksum failure: A5,10,01,55,00 (expected 44) -> single `err_chk` pulse, `cmd_valid` stays 0. A following valid packet is accepted.
- Line errors: `rx_frame_error` on the LEN byte -> `err_line` and return to HUNT. Separately, LEN = 9 with MAX_LEN = 8 -> `err_line`.
- Timeout (TIMEOUT_CYCLES = 16): A5,10 then 16 idle cycles -> `err_timeout` once and `busy` = 0. A byte arriving exactly on the expiry cycle keeps the packet alive.
- Backpressure and reset: hold `cmd_ready` = 0 and send 2 more bytes -> 2 `err_overrun` pulses and outputs unchanged. Then assert `reset_n` = 0 mid-packet -> all outputs 0 immediately.
